round_sequencer: RTL and testbench
==================================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- TICK_DIV, 100000: clk cycles per timing tick (1 ms at 100 MHz).
- CD_TICKS, 1000: ticks per countdown digit.
- MIN_DELAY, 1000: minimum random delay, in ticks.
- DELAY_MASK, 16'h0FFF: mask on LFSR bits added to MIN_DELAY.
- TIMEOUT_TICKS, 3000: maximum GO-phase wait, in ticks.
- RESULT_TICKS, 2000: result display hold, in ticks.
- WIN_SCORE, 5: round wins needed to win the game (1..99).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on its rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- start, in, 1: synchronous pulse; starts a game or the next round.
- round_over, in, 1: level from the score tracker; the round has been decided.
- winner, in, 2: round winner from the tracker (01=P1, 10=P2); valid while round_over=1.
- jump_start, in, 1: level from the tracker; the round ended by a false start.
- countdown_in_action, out, 1: high during COUNTDOWN.
- countdown_digit, out, 2: current countdown digit (3, 2, 1); 0 outside COUNTDOWN.
- round_in_action, out, 1: high in ARMED and GO.
- delay_done, out, 1: high in GO only.
- p1_wins, out, 7: P1 round-win count.
- p2_wins, out, 7: P2 round-win count.
- game_over, out, 1: high in GAME_OVER.
- game_winner, out, 2: game winner (01/10); 00 until GAME_OVER.

Function
REQ-003 Tick generator SHALL be a free-running counter 0..TICK_DIV-1 that emits a one-cycle tick on wrap; every state timer SHALL count ticks, not clk cycles.
REQ-004 FSM states SHALL be IDLE, COUNTDOWN, ARMED, GO, RESULT and GAME_OVER.
REQ-005 IDLE: all outputs 0 except the win counters, which hold; start SHALL move to COUNTDOWN with countdown_digit=3 and clear the state timer.
REQ-006 COUNTDOWN: countdown_digit SHALL decrement every CD_TICKS ticks; after digit 1 expires, the FSM SHALL enter ARMED.
REQ-007 On entry to ARMED, delay_target SHALL load MIN_DELAY + (lfsr & DELAY_MASK) (16-bit, saturating at 16'hFFFF).
REQ-008 LFSR SHALL be 16-bit, polynomial x^16+x^14+x^13+x^11+1, reset seed 16'hACE1, advancing every clk cycle in all states.
REQ-009 ARMED: after delay_target ticks, the FSM SHALL enter GO; if round_over=1 first, it SHALL enter RESULT immediately (false start).
REQ-010 GO: round_over=1 SHALL move to RESULT; if TIMEOUT_TICKS ticks elapse first, the FSM SHALL enter RESULT with no win credited.
REQ-011 On the clk edge entering RESULT from round_over, the counter selected by winner (01 -> p1_wins, 10 -> p2_wins) SHALL increment by 1; winner 00 or 11 SHALL credit nothing. jump_start needs no special handling, since the tracker already names the non-jumping player.
REQ-012 Win counters SHALL saturate at 99.
REQ-013 RESULT: the FSM SHALL hold RESULT_TICKS ticks. Then, if p1_wins or p2_wins equals WIN_SCORE, it SHALL enter GAME_OVER with game_winner set accordingly; otherwise it SHALL enter IDLE.
REQ-014 GAME_OVER: outputs SHALL hold. start SHALL clear both counters and game_winner and go to COUNTDOWN.
REQ-015 start SHALL be ignored in every state other than IDLE and GAME_OVER.
REQ-016 If round_over and a timer expiry occur in the same cycle, round_over SHALL take priority.
REQ-017 All outputs SHALL be registered, i.e. decoded from the state register with no combinational input-to-output path.

Reset
REQ-018 While rst_n=0, the block SHALL set state=IDLE, all outputs=0, timers=0, tick counter=0 and lfsr=16'hACE1, asynchronously.
REQ-019 Deasserting rst_n mid-round SHALL restart in IDLE with zero scores; there SHALL be no partial-round credit.

Verification (TICK_DIV=2, CD_TICKS=2, MIN_DELAY=4, DELAY_MASK=3, TIMEOUT_TICKS=8, RESULT_TICKS=2, WIN_SCORE=2)
REQ-020 Scenario: start pulse -> countdown_digit 3,2,1 for 4 clk each -> round_in_action=1 and delay_done=0 for 8..14 clk -> delay_done=1.
REQ-021 Scenario: in ARMED, round_over=1 with winner=10 and jump_start=1 -> next cycle state RESULT, p2_wins=1, delay_done never asserted.
REQ-022 Scenario: in GO, no round_over for 16 clk -> RESULT, wins unchanged, then IDLE after 4 clk.
REQ-023 Scenario: P1 wins two rounds -> game_over=1, game_winner=01, p1_wins=2; then start -> counters 0, countdown_digit=3.
REQ-024 Scenario: rst_n low mid-GO -> all outputs 0 in the same cycle; start pulses during COUNTDOWN and ARMED are ignored.
REQ-025 Scenario: round_over rises on the same cycle as GO timeout expiry -> win credited, not treated as timeout.

Source files
------------

// File: rtl/round_sequencer.sv
// round_sequencer: round and game sequencing for a two-player reaction game.
// A free-running tick divider paces every state timer. Each round runs a
// 3-2-1 countdown, then a pseudo-random armed delay taken from an LFSR, then a
// GO window that is closed by the score tracker or by a timeout. Round wins
// are counted per player, and the game ends when a player reaches WIN_SCORE.
//
// State table
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_IDLE      | waiting for start; scores hold
//   S_COUNTDOWN | showing digits 3, 2, 1, CD_TICKS ticks each
//   S_ARMED     | random wait before GO; round_over here is a false start
//   S_GO        | players may react; bounded by TIMEOUT_TICKS
//   S_RESULT    | round decided; hold RESULT_TICKS, then check for game end
//   S_GAME_OVER | winner latched; start begins a fresh game
//
// All tick-count parameters are expected to fit in 16 bits.

module round_sequencer #(
  parameter int unsigned TICK_DIV      = 100000,
  parameter int unsigned CD_TICKS      = 1000,
  parameter int unsigned MIN_DELAY     = 1000,
  parameter logic [15:0] DELAY_MASK    = 16'h0FFF,
  parameter int unsigned TIMEOUT_TICKS = 3000,
  parameter int unsigned RESULT_TICKS  = 2000,
  parameter int unsigned WIN_SCORE     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       round_over,
  input  logic [1:0] winner,
  input  logic       jump_start,
  output logic       countdown_in_action,
  output logic [1:0] countdown_digit,
  output logic       round_in_action,
  output logic       delay_done,
  output logic [6:0] p1_wins,
  output logic [6:0] p2_wins,
  output logic       game_over,
  output logic [1:0] game_winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_ARMED,
    S_GO,
    S_RESULT,
    S_GAME_OVER
  } state_t;

  localparam int unsigned   TCW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [16:0]   CD_LIM    = 17'(CD_TICKS);
  localparam logic [16:0]   TO_LIM    = 17'(TIMEOUT_TICKS);
  localparam logic [16:0]   RES_LIM   = 17'(RESULT_TICKS);
  localparam logic [6:0]    WIN_CNT   = 7'(WIN_SCORE);
  localparam logic [6:0]    WIN_MAX   = 7'd99;
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  state_t         state;
  logic [TCW-1:0] tick_cnt;
  logic           tick;
  logic [15:0]    lfsr;
  logic           lfsr_fb;
  logic [15:0]    tmr;
  logic [16:0]    tmr_inc;
  logic [15:0]    delay_target;
  logic [31:0]    delay_sum;
  logic [15:0]    delay_load;
  logic           cd_exp;
  logic           arm_exp;
  logic           to_exp;
  logic           res_exp;
  logic           credit_p1;
  logic           credit_p2;
  logic           jump_start_unused;

  // The tracker already reports the non-jumping player as winner, so the
  // false-start flag carries no extra information for sequencing.
  assign jump_start_unused = jump_start;

  assign tick = (tick_cnt == TICK_LAST);

  // Timers count elapsed ticks since state entry; expiry is judged on the
  // tick that would bring the count up to the limit.
  assign tmr_inc = {1'b0, tmr} + 17'd1;
  assign cd_exp  = tick && (tmr_inc >= CD_LIM);
  assign arm_exp = tick && (tmr_inc >= {1'b0, delay_target});
  assign to_exp  = tick && (tmr_inc >= TO_LIM);
  assign res_exp = tick && (tmr_inc >= RES_LIM);

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  assign delay_sum  = 32'(MIN_DELAY) + {16'd0, lfsr & DELAY_MASK};
  assign delay_load = (delay_sum > 32'h0000_FFFF) ? 16'hFFFF : delay_sum[15:0];

  // Winner codes 00 and 11 credit nobody; counters stop at 99.
  assign credit_p1 = (winner == 2'b01) && (p1_wins != WIN_MAX);
  assign credit_p2 = (winner == 2'b10) && (p2_wins != WIN_MAX);

  // Free-running tick divider, one-cycle tick on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Random source for the armed delay, advancing every clock in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  // Sequencing FSM: state, state timer, delay target, scores and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      tmr                 <= '0;
      delay_target        <= '0;
      countdown_in_action <= 1'b0;
      countdown_digit     <= 2'd0;
      round_in_action     <= 1'b0;
      delay_done          <= 1'b0;
      p1_wins             <= '0;
      p2_wins             <= '0;
      game_over           <= 1'b0;
      game_winner         <= 2'b00;
    end else begin
      if (tick) begin
        tmr <= tmr + 16'd1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state               <= S_COUNTDOWN;
            tmr                 <= '0;
            countdown_in_action <= 1'b1;
            countdown_digit     <= 2'd3;
          end
        end

        S_COUNTDOWN: begin
          if (cd_exp) begin
            tmr <= '0;
            if (countdown_digit == 2'd1) begin
              state               <= S_ARMED;
              delay_target        <= delay_load;
              countdown_in_action <= 1'b0;
              countdown_digit     <= 2'd0;
              round_in_action     <= 1'b1;
            end else begin
              countdown_digit <= countdown_digit - 2'd1;
            end
          end
        end

        S_ARMED: begin
          // A decision before GO is a false start and still scores.
          if (round_over) begin
            state           <= S_RESULT;
            tmr             <= '0;
            round_in_action <= 1'b0;
            delay_done      <= 1'b0;
            if (credit_p1) p1_wins <= p1_wins + 7'd1;
            if (credit_p2) p2_wins <= p2_wins + 7'd1;
          end else if (arm_exp) begin
            state      <= S_GO;
            tmr        <= '0;
            delay_done <= 1'b1;
          end
        end

        S_GO: begin
          // round_over is tested first so a decision landing on the timeout
          // tick is still credited.
          if (round_over) begin
            state           <= S_RESULT;
            tmr             <= '0;
            round_in_action <= 1'b0;
            delay_done      <= 1'b0;
            if (credit_p1) p1_wins <= p1_wins + 7'd1;
            if (credit_p2) p2_wins <= p2_wins + 7'd1;
          end else if (to_exp) begin
            state           <= S_RESULT;
            tmr             <= '0;
            round_in_action <= 1'b0;
            delay_done      <= 1'b0;
          end
        end

        S_RESULT: begin
          if (res_exp) begin
            tmr <= '0;
            if (p1_wins == WIN_CNT) begin
              state       <= S_GAME_OVER;
              game_over   <= 1'b1;
              game_winner <= 2'b01;
            end else if (p2_wins == WIN_CNT) begin
              state       <= S_GAME_OVER;
              game_over   <= 1'b1;
              game_winner <= 2'b10;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_GAME_OVER: begin
          if (start) begin
            state               <= S_COUNTDOWN;
            tmr                 <= '0;
            p1_wins             <= '0;
            p2_wins             <= '0;
            game_over           <= 1'b0;
            game_winner         <= 2'b00;
            countdown_in_action <= 1'b1;
            countdown_digit     <= 2'd3;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
`timescale 1ns/1ps
// Bench for round_sequencer. Expected outputs come from a schedule model:
// each round is described by the clock edges at which its phases begin,
// derived from tick arithmetic and the LFSR sequence, and every cycle's
// outputs are compared against what that schedule implies.
module tb_round_sequencer;

  localparam int          TD   = 2;
  localparam int          CD   = 2;
  localparam int          MIND = 4;
  localparam logic [15:0] MASK = 16'h0003;
  localparam int          TO   = 8;
  localparam int          RT   = 2;
  localparam int          WS   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       round_over = 1'b0;
  logic [1:0] winner = 2'b00;
  logic       jump_start = 1'b0;
  logic       countdown_in_action;
  logic [1:0] countdown_digit;
  logic       round_in_action;
  logic       delay_done;
  logic [6:0] p1_wins;
  logic [6:0] p2_wins;
  logic       game_over;
  logic [1:0] game_winner;

  round_sequencer #(
    .TICK_DIV(TD), .CD_TICKS(CD), .MIN_DELAY(MIND), .DELAY_MASK(MASK),
    .TIMEOUT_TICKS(TO), .RESULT_TICKS(RT), .WIN_SCORE(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .round_over(round_over),
    .winner(winner), .jump_start(jump_start),
    .countdown_in_action(countdown_in_action), .countdown_digit(countdown_digit),
    .round_in_action(round_in_action), .delay_done(delay_done),
    .p1_wins(p1_wins), .p2_wins(p2_wins), .game_over(game_over),
    .game_winner(game_winner)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release; edge n carries a tick when n % TD == 0.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [21:0] obs;
  assign obs = {countdown_in_action, countdown_digit, round_in_action, delay_done,
                p1_wins, p2_wins, game_over, game_winner};

  int total = 0;
  int bad = 0;
  int mp1 = 0;
  int mp2 = 0;
  bit mgo = 1'b0;
  logic [1:0] mgw = 2'b00;

  function automatic logic [21:0] pack(bit cia, logic [1:0] dig, bit ria, bit dd,
                                       int p1, int p2, bit go, logic [1:0] gw);
    return {cia, dig, ria, dd, 7'(p1), 7'(p2), go, gw};
  endfunction

  function automatic int nth_tick_after(int e, int k);
    return ((e / TD) + 1) * TD + (k - 1) * TD;
  endfunction

  // LFSR contents seen by edge n: seed stepped n-1 times.
  function automatic logic [15:0] lfsr_at(int n);
    logic [15:0] v = 16'hACE1;
    for (int i = 1; i < n; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    return v;
  endfunction

  function automatic int delay_ticks(int e);
    int d = MIND + int'(lfsr_at(e) & MASK);
    return (d > 65535) ? 65535 : d;
  endfunction

  // mode: 0 win in GO, 1 false start in ARMED, 2 timeout, 3 win on the
  // timeout edge, 4 stop two cycles into GO (caller then resets).
  task automatic run_round(input int mode, input logic [1:0] win, input bit noise,
                           input string tag);
    int s, e3, e2, e1, g, tmo, r, re, x, last, d, op1, op2, np1, np2;
    bit ngo, done;
    logic [1:0] ngw;
    logic [21:0] exp_v;
    start = 1'b1;
    s   = cyc + 1;
    op1 = mgo ? 0 : mp1;
    op2 = mgo ? 0 : mp2;
    e3  = nth_tick_after(s, CD);
    e2  = nth_tick_after(e3, CD);
    e1  = nth_tick_after(e2, CD);
    d   = delay_ticks(e1);
    g   = nth_tick_after(e1, d);
    tmo = nth_tick_after(g, TO);
    case (mode)
      0:       r = g + 1 + int'($urandom_range(tmo - g - 2));
      1:       r = e1 + 1 + int'($urandom_range(g - e1 - 1));
      3:       r = tmo;
      default: r = -1;
    endcase
    re  = (r > 0) ? r : tmo;
    np1 = op1;
    np2 = op2;
    if (r > 0 && win == 2'b01) np1 = (op1 < 99) ? op1 + 1 : 99;
    if (r > 0 && win == 2'b10) np2 = (op2 < 99) ? op2 + 1 : 99;
    x   = nth_tick_after(re, RT);
    ngo = 1'b0;
    ngw = 2'b00;
    if (np1 == WS)      begin ngo = 1'b1; ngw = 2'b01; end
    else if (np2 == WS) begin ngo = 1'b1; ngw = 2'b10; end
    last = (mode == 4) ? g + 2 : x + 1;
    done = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 400 && !done; k++) begin
      int c = cyc;
      int n = cyc + 1;
      if (c < e3)      exp_v = pack(1'b1, 2'd3, 1'b0, 1'b0, op1, op2, 1'b0, 2'b00);
      else if (c < e2) exp_v = pack(1'b1, 2'd2, 1'b0, 1'b0, op1, op2, 1'b0, 2'b00);
      else if (c < e1) exp_v = pack(1'b1, 2'd1, 1'b0, 1'b0, op1, op2, 1'b0, 2'b00);
      else if (c < re) exp_v = pack(1'b0, 2'd0, 1'b1, c >= g, op1, op2, 1'b0, 2'b00);
      else if (c < x)  exp_v = pack(1'b0, 2'd0, 1'b0, 1'b0, np1, np2, 1'b0, 2'b00);
      else             exp_v = pack(1'b0, 2'd0, 1'b0, 1'b0, np1, np2, ngo, ngw);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", tag, c, obs, exp_v);
      end
      if (c >= last) begin
        done = 1'b1;
      end else begin
        start      = noise && (n < re) && ($urandom_range(2) == 0);
        round_over = (r > 0) && (n >= r) && (n <= x);
        winner     = round_over ? win : 2'($urandom);
        jump_start = round_over ? (mode == 1) : 1'($urandom);
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s budget expired got=%0d want=%0d", tag, cyc, last);
    end
    start      = 1'b0;
    round_over = 1'b0;
    jump_start = 1'b0;
    if (mode != 4) begin
      mp1 = np1;
      mp2 = np2;
      mgo = ngo;
      mgw = ngw;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    total++;
    if (obs !== 22'd0) begin bad++; $display("FAIL reset_async got=%h want=0", obs); end
    @(negedge clk);
    total++;
    if (obs !== 22'd0) begin bad++; $display("FAIL reset_hold got=%h want=0", obs); end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      round_over = 1'($urandom);
      winner     = 2'($urandom);
      @(negedge clk);
      total++;
      if (obs !== 22'd0) begin bad++; $display("FAIL idle_quiet got=%h want=0", obs); end
    end
    round_over = 1'b0;
  endtask

  task automatic test_countdown_go();
    run_round(0, 2'b01, 1'b0, "countdown_go");
    total++;
    if (p1_wins !== 7'd1) begin bad++; $display("FAIL p1_after_win got=%0d want=1", p1_wins); end
  endtask

  task automatic test_false_start();
    run_round(1, 2'b10, 1'b1, "false_start");
    total++;
    if (p2_wins !== 7'd1) begin bad++; $display("FAIL p2_after_jump got=%0d want=1", p2_wins); end
  endtask

  task automatic test_timeout();
    run_round(2, 2'b01, 1'b1, "timeout");
  endtask

  task automatic test_no_credit();
    run_round(0, 2'b11, 1'b0, "winner_11");
    run_round(0, 2'b00, 1'b0, "winner_00");
  endtask

  task automatic test_simultaneous();
    run_round(3, 2'b01, 1'b0, "ro_at_timeout");
    total++;
    if ({game_over, game_winner, p1_wins} !== {1'b1, 2'b01, 7'd2}) begin
      bad++;
      $display("FAIL game_end got=%b/%b/%0d want=1/01/2", game_over, game_winner, p1_wins);
    end
  endtask

  task automatic test_game_over_hold();
    for (int k = 0; k < 6; k++) begin
      round_over = 1'($urandom);
      winner     = 2'($urandom);
      jump_start = 1'($urandom);
      @(negedge clk);
      total++;
      if (obs !== pack(1'b0, 2'd0, 1'b0, 1'b0, mp1, mp2, mgo, mgw)) begin
        bad++;
        $display("FAIL game_over_hold got=%h want=%h", obs,
                 pack(1'b0, 2'd0, 1'b0, 1'b0, mp1, mp2, mgo, mgw));
      end
    end
    round_over = 1'b0;
    jump_start = 1'b0;
    run_round(0, 2'b10, 1'b1, "restart");
  endtask

  task automatic test_reset_mid_go();
    run_round(4, 2'b01, 1'b1, "abort_in_go");
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 22'd0) begin bad++; $display("FAIL reset_mid_go got=%h want=0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    mp1 = 0;
    mp2 = 0;
    mgo = 1'b0;
    mgw = 2'b00;
    run_round(0, 2'b10, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      int m = int'($urandom_range(3));
      logic [1:0] w;
      case ($urandom_range(3))
        0:       w = 2'b01;
        1:       w = 2'b10;
        2:       w = 2'b11;
        default: w = 2'b00;
      endcase
      run_round(m, w, 1'b1, "random_round");
    end
  endtask

  initial begin
    test_reset();
    test_countdown_go();
    test_false_start();
    test_timeout();
    test_no_credit();
    test_simultaneous();
    test_game_over_hold();
    test_reset_mid_go();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=time_limit want=finish");
    $fatal(1);
  end

endmodule
